// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset defaults and FSM state encoding.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_DEFAULT      = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/if_stage_if_id.sv
// IF/ID pipeline register: flush beats hold, hold beats load; otherwise a bubble is loaded.
module IF_ID_Register
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = NOP;
    pc4_d   = '0;
    valid_d = 1'b0;
    if (!flush) begin
      if (hold) begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
      end else if (load) begin
        instr_d = instr_in;
        pc4_d   = pc4_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr_out = instr_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch FSM with req/ack memory handshake, stall hold buffer,
// branch/jump redirect, feeding the IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        BranchTaken,
  input  logic [31:0] PC_Branch,
  input  logic        Jump,
  input  logic [31:0] PC_Jump,
  output logic [31:0] instruction_out,
  output logic [31:0] PC_plus_four_out,
  output logic        valid_out
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        ifid_load, ifid_flush, ifid_hold;
  logic [31:0] ifid_instr, ifid_pc4;

  assign redirect  = BranchTaken | Jump;
  assign target    = (BranchTaken ? PC_Branch : PC_Jump) & WORD_MASK;
  assign pc_plus4  = pc_q + 32'd4;
  assign imem_req  = (state_q == FETCH) || (state_q == DRAIN);
  // While draining, pc_q already holds the redirect target; the bus keeps the abandoned address.
  assign imem_addr = (state_q == DRAIN) ? drain_addr_q : (pc_q & WORD_MASK);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_instr_d  = buf_instr_q;
    buf_pc4_d    = buf_pc4_q;
    ifid_flush   = 1'b0;
    ifid_hold    = 1'b1;
    ifid_load    = 1'b0;
    ifid_instr   = imem_rdata;
    ifid_pc4     = pc_plus4;

    if (redirect) begin
      ifid_flush = 1'b1;
      pc_d       = target;
      case (state_q)
        FETCH: begin
          if (imem_ack) begin
            state_d = FETCH;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = imem_addr;
          end
        end
        DRAIN:   state_d = imem_ack ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (stall) begin
              buf_instr_d = imem_rdata;
              buf_pc4_d   = pc_plus4;
              state_d     = HOLD;
            end else begin
              ifid_hold = 1'b0;
              ifid_load = 1'b1;
            end
          end else if (!stall) begin
            ifid_hold = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_hold  = 1'b0;
            ifid_load  = 1'b1;
            ifid_instr = buf_instr_q;
            ifid_pc4   = buf_pc4_q;
            state_d    = FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) state_d = FETCH;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC & WORD_MASK;
      drain_addr_q <= '0;
      buf_instr_q  <= NOP;
      buf_pc4_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_instr_q  <= buf_instr_d;
      buf_pc4_q    <= buf_pc4_d;
    end
  end

  IF_ID_Register #(
    .NOP (NOP)
  ) u_if_id (
    .clock     (clock),
    .reset_n   (reset_n),
    .load      (ifid_load),
    .flush     (ifid_flush),
    .hold      (ifid_hold),
    .instr_in  (ifid_instr),
    .pc4_in    (ifid_pc4),
    .instr_out (instruction_out),
    .pc4_out   (PC_plus_four_out),
    .valid_out (valid_out)
  );

endmodule
